spi_frame_receiver: RTL and testbench

Front-end SPI slave stage that feeds the PWM control register bank.
- Synchronises the asynchronous ncs/sclk/copi pins into clk.
- Deserialises 16-bit mode-0 write frames.
- Validates each frame and hands the register bank a single-cycle commit strobe with address and data.
- Replaces ad-hoc pin sampling in the register bank, so the bank only ever sees clean, validated, clk-domain transactions.

---
 rtl/spi_frame_receiver_pkg.sv | 28 ++
 rtl/spi_frame_receiver_if.sv | 27 ++
 rtl/spi_frame_receiver_pin_sync.sv | 40 ++++
 rtl/spi_frame_receiver.sv | 156 +++++++++++++++
 tb/tb_spi_frame_receiver.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_frame_receiver_pkg.sv
// Shared types and constants for the SPI frame receiver: FSM states, frame layout, counter limits.
package spi_frame_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;
    localparam int CNT_W      = 5;
    localparam int STAT_W     = 8;

    // 17 means "more than FRAME_BITS edges were seen"
    localparam logic [CNT_W-1:0] CNT_SAT = 5'd17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } rx_state_t;

    function automatic logic frame_ok(input logic [CNT_W-1:0] bit_cnt,
                                      input logic [ADDR_W-1:0] addr,
                                      input int max_addr);
        return (bit_cnt == CNT_W'(FRAME_BITS)) && (int'(addr) <= max_addr);
    endfunction

endpackage

// File: rtl/spi_frame_receiver_if.sv
// Validated-frame bus between the SPI receiver (master) and the register bank (slave).
interface spi_frame_receiver_if;
    import spi_frame_pkg::*;

    logic              frame_valid;
    logic              frame_rw;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic              frame_err;

    modport master (
        output frame_valid,
        output frame_rw,
        output frame_addr,
        output frame_data,
        output frame_err
    );

    modport slave (
        input frame_valid,
        input frame_rw,
        input frame_addr,
        input frame_data,
        input frame_err
    );

endinterface

// File: rtl/spi_frame_receiver_pin_sync.sv
// pin_sync_edge: SYNC_STAGES-deep pin synchroniser plus a history flop for rise/fall detection.
module pin_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   hist_reg;

    assign sync_next[0] = pin;

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
            assign sync_next[gi] = sync_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {SYNC_STAGES{RESET_VAL}};
            hist_reg <= RESET_VAL;
        end else begin
            sync_reg <= sync_next;
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~hist_reg;
    assign fall  = ~level & hist_reg;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave front end: synchronises pins, deserialises 16-bit frames, emits validated commits.
// Optional frame/error statistics counters are enabled by defining SPI_FRAME_RX_STATS_EN.
module spi_frame_receiver
    import spi_frame_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ncs,
    input  logic sclk,
    input  logic copi,
    spi_frame_receiver_if.master frame_bus
`ifdef SPI_FRAME_RX_STATS_EN
    ,
    output logic [STAT_W-1:0] frame_cnt,
    output logic [STAT_W-1:0] err_cnt
`endif
);

    logic ncs_level, ncs_rise, ncs_fall;
    logic sclk_rise;
    logic copi_level;
    logic sclk_level_unused, sclk_fall_unused, copi_rise_unused, copi_fall_unused;

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (ncs),
        .level (ncs_level),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall_unused)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (copi),
        .level (copi_level),
        .rise  (copi_rise_unused),
        .fall  (copi_fall_unused)
    );

    // The ncs chain resets high, so a pin held low across reset release would look like a fall.
    // Frames are only armed once the flushed synchroniser has actually observed ncs high.
    logic [SYNC_STAGES-1:0] settle_reg;
    logic                   armed_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_reg <= '0;
            armed_reg  <= 1'b0;
        end else begin
            settle_reg <= {settle_reg[SYNC_STAGES-2:0], 1'b1};
            if (settle_reg[SYNC_STAGES-1] && ncs_level) begin
                armed_reg <= 1'b1;
            end
        end
    end

    rx_state_t               state_reg;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [CNT_W-1:0]        bit_cnt_reg;
    logic                    frame_valid_reg;
    logic                    frame_err_reg;
    logic                    frame_rw_reg;
    logic [ADDR_W-1:0]       frame_addr_reg;
    logic [DATA_W-1:0]       frame_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            frame_rw_reg    <= 1'b0;
            frame_addr_reg  <= '0;
            frame_data_reg  <= '0;
        end else begin
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ncs_fall && armed_reg) begin
                        state_reg   <= SHIFT;
                        shift_reg   <= '0;
                        bit_cnt_reg <= '0;
                    end
                end
                SHIFT: begin
                    // ncs_rise takes priority: a coincident sclk edge is dropped
                    if (ncs_rise) begin
                        state_reg <= COMMIT;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_level};
                        if (bit_cnt_reg != CNT_SAT) begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state_reg <= IDLE;
                    if (frame_ok(bit_cnt_reg, shift_reg[ADDR_MSB:ADDR_LSB], MAX_ADDR)) begin
                        frame_valid_reg <= 1'b1;
                        frame_rw_reg    <= shift_reg[RW_BIT];
                        frame_addr_reg  <= shift_reg[ADDR_MSB:ADDR_LSB];
                        frame_data_reg  <= shift_reg[DATA_W-1:0];
                    end else begin
                        frame_err_reg   <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign frame_bus.frame_valid = frame_valid_reg;
    assign frame_bus.frame_err   = frame_err_reg;
    assign frame_bus.frame_rw    = frame_rw_reg;
    assign frame_bus.frame_addr  = frame_addr_reg;
    assign frame_bus.frame_data  = frame_data_reg;

`ifdef SPI_FRAME_RX_STATS_EN
    logic [STAT_W-1:0] frame_cnt_reg;
    logic [STAT_W-1:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
        end else begin
            if (frame_valid_reg && (frame_cnt_reg != {STAT_W{1'b1}})) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
            if (frame_err_reg && (err_cnt_reg != {STAT_W{1'b1}})) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign frame_cnt = frame_cnt_reg;
    assign err_cnt   = err_cnt_reg;
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed, table-driven bench for spi_frame_receiver; stats checks run when SPI_FRAME_RX_STATS_EN is defined.
module tb_spi_frame_receiver;
    import spi_frame_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_ADDR    = 4;
    localparam int LATENCY     = SYNC_STAGES + 2;
    localparam int HALF_SLOW   = 4;
    localparam int HALF_FAST   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ncs   = 1'b1;
    logic sclk  = 1'b0;
    logic copi  = 1'b0;

    spi_frame_receiver_if bus ();

`ifdef SPI_FRAME_RX_STATS_EN
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;
`endif

    spi_frame_receiver #(
        .SYNC_STAGES (SYNC_STAGES),
        .MAX_ADDR    (MAX_ADDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ncs       (ncs),
        .sclk      (sclk),
        .copi      (copi),
        .frame_bus (bus)
`ifdef SPI_FRAME_RX_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int tot_valid = 0;
    int tot_err   = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_valid) tot_valid++;
            if (bus.frame_err)   tot_err++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one frame of nbits (MSB first); with coinc the last sclk rise lands with ncs rise.
    task automatic send_frame(input logic [31:0] word, input int nbits, input bit coinc, input int half);
        @(negedge clk);
        ncs = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = word[i];
            repeat (half) @(negedge clk);
            if (coinc && i == 0) begin
                sclk = 1'b1;
                ncs  = 1'b1;
            end else begin
                sclk = 1'b1;
                repeat (half) @(negedge clk);
                sclk = 1'b0;
            end
        end
        if (!(coinc && nbits > 0)) begin
            repeat (half) @(negedge clk);
            ncs = 1'b1;
        end
    endtask

    // Watches a bounded window after ncs rises; reports strobe counts and first-strobe cycle.
    task automatic observe(output int nv, output int ne, output int first);
        nv = 0;
        ne = 0;
        first = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.frame_valid) nv++;
            if (bus.frame_err)   ne++;
            if ((bus.frame_valid || bus.frame_err) && first == 0) first = c;
        end
        sclk = 1'b0;
    endtask

    typedef struct {
        logic [31:0] word;
        int          nbits;
        bit          coinc;
        bit          exp_valid;
        bit          exp_rw;
        logic [6:0]  exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int nv, ne, first;
        int exp_tot_valid, exp_tot_err;

        vecs[0] = '{32'h0000_8255, 16, 1'b0, 1'b1, 1'b1, 7'h02, 8'h55};
        vecs[1] = '{32'h0000_0400, 16, 1'b0, 1'b1, 1'b0, 7'h04, 8'h00};
        vecs[2] = '{32'h0000_85AA, 16, 1'b0, 1'b0, 1'b0, 7'h04, 8'h00};
        vecs[3] = '{32'h0000_7FFF, 15, 1'b0, 1'b0, 1'b0, 7'h04, 8'h00};
        vecs[4] = '{32'h0001_8255, 17, 1'b0, 1'b0, 1'b0, 7'h04, 8'h00};
        vecs[5] = '{32'h0000_0000,  0, 1'b0, 1'b0, 1'b0, 7'h04, 8'h00};
        vecs[6] = '{32'h0000_8311, 16, 1'b1, 1'b0, 1'b0, 7'h04, 8'h00};
        vecs[7] = '{32'h0000_8311, 16, 1'b0, 1'b1, 1'b1, 7'h03, 8'h11};
        vecs[8] = '{32'h0000_847F, 16, 1'b0, 1'b1, 1'b1, 7'h04, 8'h7F};

        exp_tot_valid = 0;
        exp_tot_err   = 0;

        repeat (3) @(negedge clk);
        check("reset_valid", 32'(bus.frame_valid), 32'h0);
        check("reset_err",   32'(bus.frame_err),   32'h0);
        check("reset_rw",    32'(bus.frame_rw),    32'h0);
        check("reset_addr",  32'(bus.frame_addr),  32'h0);
        check("reset_data",  32'(bus.frame_data),  32'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            send_frame(vecs[v].word, vecs[v].nbits, vecs[v].coinc, HALF_SLOW);
            observe(nv, ne, first);
            exp_tot_valid += int'(vecs[v].exp_valid);
            exp_tot_err   += int'(!vecs[v].exp_valid);
            $display("vec %0d word=0x%0h bits=%0d coinc=%0d: valid_pulses=%0d err_pulses=%0d lat=%0d rw=%0d addr=0x%0h data=0x%0h",
                     v, vecs[v].word, vecs[v].nbits, vecs[v].coinc, nv, ne, first,
                     bus.frame_rw, bus.frame_addr, bus.frame_data);
            check($sformatf("vec%0d_valid_pulses", v), 32'(nv), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_err_pulses", v),   32'(ne), 32'(!vecs[v].exp_valid));
            check($sformatf("vec%0d_latency", v),      32'(first), 32'(LATENCY));
            check($sformatf("vec%0d_rw", v),   32'(bus.frame_rw),   32'(vecs[v].exp_rw));
            check($sformatf("vec%0d_addr", v), 32'(bus.frame_addr), 32'(vecs[v].exp_addr));
            check($sformatf("vec%0d_data", v), 32'(bus.frame_data), 32'(vecs[v].exp_data));
            repeat (4) @(negedge clk);
        end

        // Mid-frame reset: 9 bits of 0x8133, then reset while ncs is still low.
        begin
            logic [15:0] w;
            w = 16'h8133;
            @(negedge clk);
            ncs = 1'b0;
            repeat (HALF_SLOW) @(negedge clk);
            for (int i = 15; i >= 7; i--) begin
                copi = w[i];
                repeat (HALF_SLOW) @(negedge clk);
                sclk = 1'b1;
                repeat (HALF_SLOW) @(negedge clk);
                sclk = 1'b0;
            end
            rst_n = 1'b0;
            #2;
            check("midreset_valid", 32'(bus.frame_valid), 32'h0);
            check("midreset_addr",  32'(bus.frame_addr),  32'h0);
            check("midreset_data",  32'(bus.frame_data),  32'h0);
            check("midreset_rw",    32'(bus.frame_rw),    32'h0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (6) @(negedge clk);
            // ncs was low at release: clocking bits and raising ncs must not produce a frame
            for (int i = 0; i < 16; i++) begin
                repeat (HALF_SLOW) @(negedge clk);
                sclk = 1'b1;
                repeat (HALF_SLOW) @(negedge clk);
                sclk = 1'b0;
            end
            repeat (HALF_SLOW) @(negedge clk);
            ncs = 1'b1;
            observe(nv, ne, first);
            $display("ncs-low-at-release sequence: valid_pulses=%0d err_pulses=%0d", nv, ne);
            check("low_release_valid", 32'(nv), 32'h0);
            check("low_release_err",   32'(ne), 32'h0);

            send_frame({16'h0, w}, 16, 1'b0, HALF_SLOW);
            observe(nv, ne, first);
            exp_tot_valid += 1;
            $display("post-reset 0x8133: valid_pulses=%0d err_pulses=%0d lat=%0d rw=%0d addr=0x%0h data=0x%0h",
                     nv, ne, first, bus.frame_rw, bus.frame_addr, bus.frame_data);
            check("post_reset_valid", 32'(nv), 32'h1);
            check("post_reset_err",   32'(ne), 32'h0);
            check("post_reset_lat",   32'(first), 32'(LATENCY));
            check("post_reset_rw",    32'(bus.frame_rw),   32'h1);
            check("post_reset_addr",  32'(bus.frame_addr), 32'h01);
            check("post_reset_data",  32'(bus.frame_data), 32'h33);
        end

`ifdef SPI_FRAME_RX_STATS_EN
        // Counters were cleared by the mid-frame reset; one valid frame since then.
        check("stats_start_frames", 32'(frame_cnt), 32'd1);
        check("stats_start_errs",   32'(err_cnt),   32'd0);
        for (int n = 0; n < 300; n++) begin
            send_frame(32'h0000_8000 | 32'(n[7:0]), 16, 1'b0, HALF_FAST);
            observe(nv, ne, first);
        end
        exp_tot_valid += 300;
        for (int n = 0; n < 2; n++) begin
            send_frame(32'h0000_FF00, 16, 1'b0, HALF_FAST);
            observe(nv, ne, first);
        end
        exp_tot_err += 2;
        $display("stats: frame_cnt=%0d err_cnt=%0d", frame_cnt, err_cnt);
        check("stats_frame_cnt_sat", 32'(frame_cnt), 32'd255);
        check("stats_err_cnt",       32'(err_cnt),   32'd2);
`endif

        repeat (4) @(negedge clk);
        $display("totals: valid=%0d err=%0d", tot_valid, tot_err);
        check("total_valid_strobes", 32'(tot_valid), 32'(exp_tot_valid));
        check("total_err_strobes",   32'(tot_err),   32'(exp_tot_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
